fetch_stage: RTL

- Fetch stage directly upstream of the IF/ID pipeline register. It owns the PC and issues in-order word requests to an instruction memory port with valid/ready handshake and variable response latency.
- Returned words are buffered in a small in-order fetch queue. The queue head is presented as instrF/PCF/PCPlus4F to the IF/ID register.
- Handles the hazard-unit stall and execute-stage branch/jump redirects, including discarding in-flight responses after a redirect.

---
 rtl/fetch_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues in-order word requests to instruction memory,
// buffers responses in a small queue and presents the head to the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        validF
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic [31:0]            resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic [CNT_W-1:0]       drop_q, drop_d;
    logic [DEPTH-1:0][31:0] entry_pc_q, entry_pc_d;
    logic [DEPTH-1:0][31:0] entry_instr_q, entry_instr_d;

    logic [CNT_W:0] inflight;
    logic           can_issue;
    logic           req_fire;
    logic           push;
    logic           pop;
    logic           queue_nonempty;

    // Credits cover both in-flight requests and queued entries, so a response
    // can never find the queue full.
    always_comb begin
        inflight       = {1'b0, outstanding_q} + {1'b0, count_q};
        can_issue      = inflight < CREDIT_LIMIT;
        queue_nonempty = count_q != '0;
        imem_req_valid = rst_n & ~PCSrcE & can_issue;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid & imem_req_ready;
        push           = imem_resp_valid & ~PCSrcE & (drop_q == '0);
        pop            = queue_nonempty & ~stallF & ~PCSrcE;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (PCSrcE) begin
            fetch_pc_d = PCTargetE;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_comb begin
        resp_pc_d = resp_pc_q;
        if (PCSrcE) begin
            resp_pc_d = PCTargetE;
        end else if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({req_fire, imem_resp_valid})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // On redirect every request still in flight after this cycle's response
    // belongs to the discarded path; no request is issued in a redirect cycle.
    always_comb begin
        drop_d = drop_q;
        if (PCSrcE) begin
            drop_d = imem_resp_valid ? (outstanding_q - CNT_ONE) : outstanding_q;
        end else if (imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_ONE;
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (PCSrcE) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        entry_pc_d    = entry_pc_q;
        entry_instr_d = entry_instr_q;
        if (push) begin
            entry_pc_d[wr_ptr_q]    = resp_pc_q;
            entry_instr_d[wr_ptr_q] = imem_resp_data;
        end
    end

    always_comb begin
        validF   = queue_nonempty;
        instrF   = NOP_INSTR;
        PCF      = '0;
        PCPlus4F = '0;
        if (queue_nonempty) begin
            instrF   = entry_instr_q[rd_ptr_q];
            PCF      = entry_pc_q[rd_ptr_q];
            PCPlus4F = entry_pc_q[rd_ptr_q] + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_pc_q    <= entry_pc_d;
        entry_instr_q <= entry_instr_d;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_q == CNT_W'(DEPTH))));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop_q <= outstanding_q);

endmodule
